// File: rtl/inv_key_schedule_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_schedule_seq_if
// Purpose  : Handshake bundle for the sequential AES-128 round-key engine.
//            Key side  : key_valid / key_ready / key_in / mode
//            Round side: rk_valid / rk_ready / rk_out / rk_index / rk_last
//            Status    : busy
//            master = key producer / round-key consumer, slave = engine.
// Revision : 1.0 - initial release
// ============================================================================
interface inv_key_schedule_seq_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         mode;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         rk_last;
    logic         busy;

    modport master (
        output key_valid, key_in, mode, rk_ready,
        input  key_ready, rk_valid, rk_out, rk_index, rk_last, busy
    );

    modport slave (
        input  key_valid, key_in, mode, rk_ready,
        output key_ready, rk_valid, rk_out, rk_index, rk_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/inv_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_schedule_seq
// Purpose  : Sequential AES-128 round-key engine. Accepts one cipher key per
//            job and streams rk0..rk10 (encrypt) or rk10..rk0 (decrypt), one
//            key per accepted transfer. A single 4-byte S-box bank serves both
//            the forward and the inverse key step. An optional cache of
//            {key, rk10} from the last pre-expansion lets a repeated decrypt
//            key skip the 10-cycle pre-expansion.
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous active-high reset (aborts any job)
//            kif.slave - key handshake, round-key handshake, busy status
// Revision : 1.0 - initial release
// ============================================================================
module inv_key_schedule_seq #(
    parameter int CACHE_EN = 1,
    parameter int NR       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    inv_key_schedule_seq_if.slave kif
);

    generate
        if (NR != 10) begin : g_nr_invalid
            $error("inv_key_schedule_seq supports NR = 10 only");
        end
    endgenerate

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_preexp = 2'd1;
    localparam logic [1:0] c_st_emit   = 2'd2;

    // Forward AES S-box, byte 0x00 in the top eight bits.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bits [2047-8b -: 8]; 2047-8b is {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_sbox[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd0:    v = 8'h01;
            4'd1:    v = 8'h02;
            4'd2:    v = 8'h04;
            4'd3:    v = 8'h08;
            4'd4:    v = 8'h10;
            4'd5:    v = 8'h20;
            4'd6:    v = 8'h40;
            4'd7:    v = 8'h80;
            4'd8:    v = 8'h1b;
            4'd9:    v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    logic [1:0]   r_state;
    logic [127:0] r_cur;
    logic [3:0]   r_idx;
    logic [3:0]   r_cnt;
    logic         r_mode;
    logic         r_last;
    logic [127:0] r_job_key;
    logic         r_cache_vld;
    logic [127:0] r_cache_key;
    logic [127:0] r_cache_rk10;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic         w_inv_step;
    logic [31:0]  w_inv_w3;
    logic [31:0]  w_sb_in;
    logic [31:0]  w_rot;
    logic [3:0]   w_rc_sel;
    logic [31:0]  w_t;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [127:0] w_fwd;
    logic [127:0] w_inv;
    logic         w_hit;

    assign {w_w0, w_w1, w_w2, w_w3} = r_cur;

    // The inverse step first rebuilds the previous w3, and that word (not
    // the current w3) is what feeds the shared S-box bank.
    assign w_inv_step = (r_state == c_st_emit) && r_mode;
    assign w_inv_w3   = w_w3 ^ w_w2;
    assign w_sb_in    = w_inv_step ? w_inv_w3 : w_w3;
    assign w_rot      = {w_sb_in[23:0], w_sb_in[31:24]};

    // Step r -> r+1 and its undo r+1 -> r share rcon[r]. In decrypt EMIT the
    // current index is r+1, so the round constant is looked up at idx-1.
    always_comb begin
        w_rc_sel = r_idx;
        if (r_state == c_st_preexp) begin
            w_rc_sel = r_cnt;
        end else if (r_mode) begin
            w_rc_sel = r_idx - 4'd1;
        end
    end

    assign w_t = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {rcon(w_rc_sel), 24'h000000};

    assign w_f0  = w_w0 ^ w_t;
    assign w_f1  = w_w1 ^ w_f0;
    assign w_f2  = w_w2 ^ w_f1;
    assign w_f3  = w_w3 ^ w_f2;
    assign w_fwd = {w_f0, w_f1, w_f2, w_f3};

    assign w_inv = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_inv_w3};

    assign w_hit = (CACHE_EN != 0) && r_cache_vld && (kif.key_in == r_cache_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cur       <= '0;
            r_idx       <= 4'd0;
            r_cnt       <= 4'd0;
            r_mode      <= 1'b0;
            r_last      <= 1'b0;
            r_cache_vld <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (kif.key_valid) begin
                        r_mode <= kif.mode;
                        r_last <= 1'b0;
                        if (!kif.mode) begin
                            r_cur   <= kif.key_in;
                            r_idx   <= 4'd0;
                            r_state <= c_st_emit;
                        end else if (w_hit) begin
                            r_cur   <= r_cache_rk10;
                            r_idx   <= 4'd10;
                            r_state <= c_st_emit;
                        end else begin
                            r_cur     <= kif.key_in;
                            r_job_key <= kif.key_in;
                            r_cnt     <= 4'd0;
                            r_state   <= c_st_preexp;
                        end
                    end
                end
                c_st_preexp: begin
                    r_cur <= w_fwd;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_idx   <= 4'd10;
                        r_state <= c_st_emit;
                        if (CACHE_EN != 0) begin
                            r_cache_key  <= r_job_key;
                            r_cache_rk10 <= w_fwd;
                            r_cache_vld  <= 1'b1;
                        end
                    end
                end
                c_st_emit: begin
                    if (kif.rk_ready) begin
                        if (r_last) begin
                            r_last  <= 1'b0;
                            r_state <= c_st_idle;
                        end else if (r_mode) begin
                            r_cur  <= w_inv;
                            r_idx  <= r_idx - 4'd1;
                            r_last <= (r_idx == 4'd1);
                        end else begin
                            r_cur  <= w_fwd;
                            r_idx  <= r_idx + 4'd1;
                            r_last <= (r_idx == 4'd9);
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // key_ready is gated by rst so no job can be taken while reset is held.
    assign kif.key_ready = (r_state == c_st_idle) && !rst;
    assign kif.rk_valid  = (r_state == c_st_emit);
    assign kif.rk_out    = r_cur;
    assign kif.rk_index  = r_idx;
    assign kif.rk_last   = r_last;
    assign kif.busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_inv_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_key_schedule_seq
// Purpose  : Self-checking bench for inv_key_schedule_seq. Expected round keys
//            come from a word-array AES-128 key expansion model and are queued
//            per job, then popped as the engine hands keys over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_key_schedule_seq;

    localparam logic [127:0] c_key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_key_b = 128'h000102030405060708090a0b0c0d0e0f;

    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct packed {
        logic [127:0] rk;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           total = 0;
    int           bad = 0;
    int           n_xfer = 0;
    exp_t         exp_q[$];
    logic [127:0] m_rk   [0:10];
    logic [127:0] obs_rk [0:10];
    bit           stalled = 1'b0;
    logic [133:0] held;

    always #5 clk = ~clk;

    inv_key_schedule_seq_if bus ();

    inv_key_schedule_seq #(
        .CACHE_EN (1),
        .NR       (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (bus)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] b);
        return c_sbox[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] x);
        return {sb(x[23:16]), sb(x[15:8]), sb(x[7:0]), sb(x[31:24])};
    endfunction

    // Textbook word-array expansion: w[i] = w[i-4] ^ temp, rcon by doubling.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = 32'(key >> (96 - 32 * i));
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if ((i % 4) == 0) begin
                t  = sub_rot(t) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_job(input logic [127:0] k, input logic m);
        exp_t e;
        model_expand(k);
        for (int r = 0; r <= 10; r++) begin
            obs_rk[r] = 'x;
            e.rk   = m ? m_rk[10-r] : m_rk[r];
            e.idx  = m ? 4'(10 - r) : 4'(r);
            e.last = (r == 10);
            exp_q.push_back(e);
        end
    endtask

    // Observe at the sample point, then advance one clock.
    task automatic step();
        exp_t e;
        if (stalled)
            chk("stall_hold", 160'({bus.rk_valid, bus.rk_out, bus.rk_index, bus.rk_last}), 160'(held));
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
            chk("no_spurious_rk_valid", 160'(bus.rk_valid), 160'(0));
        end else if (bus.rk_valid) begin
            e = exp_q[0];
            chk("rk_stream", 160'({bus.rk_out, bus.rk_index, bus.rk_last}), 160'({e.rk, e.idx, e.last}));
            if (bus.rk_ready) begin
                obs_rk[bus.rk_index] = bus.rk_out;
                void'(exp_q.pop_front());
                n_xfer++;
            end else begin
                stalled = 1'b1;
                held    = {1'b1, bus.rk_out, bus.rk_index, bus.rk_last};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_job(input logic [127:0] k, input logic m);
        int n;
        n = 0;
        bus.key_valid = 1'b1;
        bus.key_in    = k;
        bus.mode      = m;
        while (!bus.key_ready && n < 100) begin
            step();
            n++;
        end
        chk("accept_ready", 160'(bus.key_ready), 160'(1));
        push_job(k, m);
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_first(input int exp_lat, input string tag);
        int lat;
        lat = 1;
        while (!bus.rk_valid && lat < 40) begin
            step();
            lat++;
        end
        chk(tag, 160'(lat), 160'(exp_lat));
    endtask

    task automatic drain(input bit rnd, input bit kr_low, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            if (rnd) bus.rk_ready = ($urandom_range(0, 1) == 1);
            if (kr_low) chk("key_ready_low_while_busy", 160'(bus.key_ready), 160'(0));
            step();
            n++;
        end
        chk("drain_complete", 160'(exp_q.size()), 160'(0));
        bus.rk_ready = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk(tag, 160'({bus.rk_valid, bus.rk_out, bus.rk_index, bus.rk_last, bus.busy, bus.key_ready}), 160'(0));
        rst = 1'b0;
        #1;
        chk({tag, "_release"},
            160'({bus.rk_valid, bus.rk_out, bus.rk_index, bus.rk_last, bus.busy, bus.key_ready}), 160'(1));
        exp_q.delete();
        stalled = 1'b0;
    endtask

    initial begin
        int n;
        int nx0;
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.mode      = 1'b0;
        bus.rk_ready  = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold",
            160'({bus.rk_valid, bus.rk_out, bus.rk_index, bus.rk_last, bus.busy, bus.key_ready}), 160'(0));
        rst = 1'b0;
        #1;
        chk("reset_release",
            160'({bus.rk_valid, bus.rk_out, bus.rk_index, bus.rk_last, bus.busy, bus.key_ready}), 160'(1));

        // Encrypt order, continuous consumer
        bus.rk_ready = 1'b1;
        send_job(c_key_a, 1'b0);
        wait_first(1, "enc_latency");
        drain(1'b0, 1'b0, n);
        chk("enc_burst_cycles", 160'(n), 160'(11));
        chk("enc_rk1", 160'(obs_rk[1]), 160'(128'ha0fafe1788542cb123a339392a6c7605));
        chk("enc_rk10", 160'(obs_rk[10]), 160'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        chk("enc_idle_after_last", 160'({bus.rk_valid, bus.busy, bus.key_ready}), 160'(3'b001));

        // Decrypt, first time for this key: full pre-expansion
        send_job(c_key_a, 1'b1);
        chk("dec_preexp_status", 160'({bus.busy, bus.key_ready, bus.rk_valid}), 160'(3'b100));
        wait_first(11, "dec_uncached_latency");
        drain(1'b0, 1'b0, n);
        chk("dec_rk10", 160'(obs_rk[10]), 160'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        chk("dec_rk1", 160'(obs_rk[1]), 160'(128'ha0fafe1788542cb123a339392a6c7605));
        chk("dec_rk0", 160'(obs_rk[0]), 160'(c_key_a));

        // Same key again: cache hit
        send_job(c_key_a, 1'b1);
        wait_first(1, "dec_cached_latency");
        drain(1'b0, 1'b0, n);
        chk("dec_cached_rk0", 160'(obs_rk[0]), 160'(c_key_a));

        // New key: cache miss
        send_job(c_key_b, 1'b1);
        wait_first(11, "dec_newkey_latency");
        drain(1'b0, 1'b0, n);
        chk("dec_newkey_rk10", 160'(obs_rk[10]), 160'(128'h13111d7fe3944a17f307a78b4d2b30c5));

        // Backpressure on a decrypt stream
        send_job(c_key_b, 1'b1);
        wait_first(1, "bp_cached_latency");
        nx0 = n_xfer;
        drain(1'b1, 1'b0, n);
        chk("bp_transfer_count", 160'(n_xfer - nx0), 160'(11));

        // Reset in the middle of pre-expansion
        send_job(c_key_a, 1'b1);
        repeat (4) step();
        chk("preexp_cycle5_busy", 160'({bus.busy, bus.rk_valid}), 160'(2'b10));
        do_reset("rst_preexp");
        send_job(c_key_a, 1'b1);
        wait_first(11, "after_rst_preexp_latency");
        drain(1'b0, 1'b0, n);

        // Reset in the middle of emission; the cache must be dropped
        send_job(c_key_a, 1'b1);
        wait_first(1, "pre_rst_emit_cached_latency");
        n = 0;
        while (bus.rk_index != 4'd4 && n < 20) begin
            step();
            n++;
        end
        chk("emit_reached_idx4", 160'({bus.rk_valid, bus.rk_index}), 160'(5'h14));
        do_reset("rst_emit");
        send_job(c_key_a, 1'b1);
        wait_first(11, "after_rst_emit_uncached_latency");
        drain(1'b0, 1'b0, n);

        // key_valid held while busy: taken only once the job has finished
        send_job(c_key_a, 1'b0);
        bus.key_valid = 1'b1;
        bus.key_in    = c_key_b;
        bus.mode      = 1'b0;
        drain(1'b0, 1'b1, n);
        chk("key_ready_after_last", 160'({bus.key_ready, bus.busy}), 160'(2'b10));
        push_job(c_key_b, 1'b0);
        step();
        bus.key_valid = 1'b0;
        wait_first(1, "held_key_latency");
        drain(1'b0, 1'b0, n);
        chk("held_key_rk0", 160'(obs_rk[0]), 160'(c_key_b));
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
